// File: rtl/exu_bju_pipe_if.sv
// Signal bundle for the EX branch/jump unit: EX offer, shared-calculator request, writeback result.
// The slave modport is the unit's view; the master modport is the surrounding pipeline's view.
interface exu_bju_pipe_if #(
    parameter int XLEN = 32
);
    logic            hs_ex4bj_val;
    logic            hs_bj4ex_rdy;
    logic [7:0]      i_op;
    logic [XLEN-1:0] i_opn1;
    logic [XLEN-1:0] i_opn2;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] i_pc;
    logic            i_pred_taken;
    logic [XLEN-1:0] i_pred_pc;
    logic            i_flush;
    logic            hs_al4cal_val;
    logic            hs_cal4al_rdy;
    logic [XLEN-1:0] o_cal_opn1;
    logic [XLEN-1:0] o_cal_opn2;
    logic [XLEN-1:0] i_cal_res;
    logic            hs_bj4wb_val;
    logic            hs_wb4bj_rdy;
    logic [XLEN-1:0] o_res;
    logic            o_taken;
    logic            o_setpc;
    logic [XLEN-1:0] o_newpc;
    logic            o_misalign;

    modport slave (
        input  hs_ex4bj_val, i_op, i_opn1, i_opn2, i_imm, i_pc, i_pred_taken, i_pred_pc,
               i_flush, hs_cal4al_rdy, i_cal_res, hs_wb4bj_rdy,
        output hs_bj4ex_rdy, hs_al4cal_val, o_cal_opn1, o_cal_opn2, hs_bj4wb_val,
               o_res, o_taken, o_setpc, o_newpc, o_misalign
    );

    modport master (
        output hs_ex4bj_val, i_op, i_opn1, i_opn2, i_imm, i_pc, i_pred_taken, i_pred_pc,
               i_flush, hs_cal4al_rdy, i_cal_res, hs_wb4bj_rdy,
        input  hs_bj4ex_rdy, hs_al4cal_val, o_cal_opn1, o_cal_opn2, hs_bj4wb_val,
               o_res, o_taken, o_setpc, o_newpc, o_misalign
    );
endinterface

// File: rtl/exu_bju_pipe.sv
// Multi-cycle branch/jump resolution unit: IDLE -> CALQ (compare, target via shared adder) -> RESP.
// Optional macro CIRNO_BJU_MISALIGN_EN adds a target alignment check that suppresses the redirect.
module exu_bju_pipe #(
    parameter int XLEN   = 32,
    parameter int PC_INC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    exu_bju_pipe_if.slave       bus,
    output logic [1:0]          dbg_state_o
);
    // Handshakes: a transfer happens on a rising clk edge where val and rdy are both 1;
    // once val is raised, the offering side holds val and its payload stable until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALQ = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [XLEN-1:0] opn1_q, opn1_d;
    logic [XLEN-1:0] opn2_q, opn2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pred_taken_q, pred_taken_d;
    logic [XLEN-1:0] pred_pc_q, pred_pc_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            taken_q, taken_d;
    logic            setpc_q, setpc_d;
    logic [XLEN-1:0] newpc_q, newpc_d;
    logic            misalign_q, misalign_d;

    logic [7:0]      sel;
    logic            is_uns;
    logic            is_jmp;
    logic [XLEN:0]   ext1, ext2, diff;
    logic            eq, lt;
    logic            cond_taken;
    logic [XLEN-1:0] pc_link;
    logic [XLEN-1:0] target;
    logic            mis;
    logic            cal_val;

    // Lowest set bit of the op wins, so multi-hot ops resolve deterministically.
    assign sel    = op_q & (~op_q + 8'd1);
    assign is_uns = sel[4] | sel[5];
    assign is_jmp = sel[6] | sel[7];
    assign ext1   = {(is_uns ? 1'b0 : opn1_q[XLEN-1]), opn1_q};
    assign ext2   = {(is_uns ? 1'b0 : opn2_q[XLEN-1]), opn2_q};
    assign diff   = ext1 - ext2;
    assign lt     = diff[XLEN];
    assign eq     = (opn1_q == opn2_q);
    assign cond_taken = (sel[0] & eq) | (sel[1] & ~eq) | (sel[2] & lt) | (sel[3] & ~lt)
                      | (sel[4] & lt) | (sel[5] & ~lt) | is_jmp;

    assign pc_link = pc_q + XLEN'(PC_INC);
    assign target  = bus.i_cal_res & ~{{(XLEN-1){1'b0}}, sel[7]};

`ifdef CIRNO_BJU_MISALIGN_EN
    assign mis = (target[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        opn1_d       = opn1_q;
        opn2_d       = opn2_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        pred_taken_d = pred_taken_q;
        pred_pc_d    = pred_pc_q;
        res_d        = res_q;
        taken_d      = taken_q;
        setpc_d      = setpc_q;
        newpc_d      = newpc_q;
        misalign_d   = misalign_q;
        cal_val      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.i_flush && bus.hs_ex4bj_val) begin
                    op_d         = bus.i_op;
                    opn1_d       = bus.i_opn1;
                    opn2_d       = bus.i_opn2;
                    imm_d        = bus.i_imm;
                    pc_d         = bus.i_pc;
                    pred_taken_d = bus.i_pred_taken;
                    pred_pc_d    = bus.i_pred_pc;
                    state_d      = CALQ;
                end
            end
            CALQ: begin
                if (bus.i_flush) begin
                    state_d = IDLE;
                end else if (!cond_taken) begin
                    res_d      = '0;
                    taken_d    = 1'b0;
                    setpc_d    = pred_taken_q;
                    newpc_d    = pc_link;
                    misalign_d = 1'b0;
                    state_d    = RESP;
                end else begin
                    cal_val = 1'b1;
                    if (bus.hs_cal4al_rdy) begin
                        res_d      = is_jmp ? pc_link : '0;
                        taken_d    = 1'b1;
                        setpc_d    = (~pred_taken_q | (target != pred_pc_q)) & ~mis;
                        newpc_d    = target;
                        misalign_d = mis;
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.i_flush || bus.hs_wb4bj_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            opn1_q       <= '0;
            opn2_q       <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
            res_q        <= '0;
            taken_q      <= 1'b0;
            setpc_q      <= 1'b0;
            newpc_q      <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            opn1_q       <= opn1_d;
            opn2_q       <= opn2_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
            res_q        <= res_d;
            taken_q      <= taken_d;
            setpc_q      <= setpc_d;
            newpc_q      <= newpc_d;
            misalign_q   <= misalign_d;
        end
    end

    // Adder operands are driven only while requesting, so the bus idles at zero.
    assign bus.hs_bj4ex_rdy  = (state_q == IDLE) & ~bus.i_flush;
    assign bus.hs_al4cal_val = cal_val;
    assign bus.o_cal_opn1    = cal_val ? (sel[7] ? opn1_q : pc_q) : '0;
    assign bus.o_cal_opn2    = cal_val ? imm_q : '0;
    assign bus.hs_bj4wb_val  = (state_q == RESP);
    assign bus.o_res         = res_q;
    assign bus.o_taken       = taken_q;
    assign bus.o_setpc       = setpc_q;
    assign bus.o_newpc       = newpc_q;
    assign bus.o_misalign    = misalign_q & (state_q == RESP);
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_exu_bju_pipe.sv
// Directed bench for exu_bju_pipe: vector table with immediate grants, then hand-written
// backpressure and flush sequences.
module tb_exu_bju_pipe;
    localparam int XLEN = 32;
`ifdef CIRNO_BJU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALQ = 2'd1;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fails;

    exu_bju_pipe_if #(.XLEN(XLEN)) bif ();

    exu_bju_pipe #(.XLEN(XLEN), .PC_INC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bif),
        .dbg_state_o (dbg_state)
    );

    // Shared calculator model: a plain adder.
    assign bif.i_cal_res = bif.o_cal_opn1 + bif.o_cal_opn2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] opn1, opn2, imm, pc;
        logic        pred_taken;
        logic [31:0] pred_pc;
        logic        exp_cal;
        logic [31:0] exp_c1, exp_c2;
        logic        exp_taken, exp_setpc;
        logic [31:0] exp_newpc, exp_res;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[13];
    vec_t v_beq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        bif.hs_ex4bj_val = 1'b1;
        bif.i_op         = v.op;
        bif.i_opn1       = v.opn1;
        bif.i_opn2       = v.opn2;
        bif.i_imm        = v.imm;
        bif.i_pc         = v.pc;
        bif.i_pred_taken = v.pred_taken;
        bif.i_pred_pc    = v.pred_pc;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        check($sformatf("v%0d_ex_rdy", idx), {31'd0, bif.hs_bj4ex_rdy}, 32'd1);
        drive_op(v);
        @(negedge clk);
        bif.hs_ex4bj_val = 1'b0;
        check($sformatf("v%0d_cal_val", idx), {31'd0, bif.hs_al4cal_val}, {31'd0, v.exp_cal});
        if (v.exp_cal) begin
            check($sformatf("v%0d_cal_opn1", idx), bif.o_cal_opn1, v.exp_c1);
            check($sformatf("v%0d_cal_opn2", idx), bif.o_cal_opn2, v.exp_c2);
        end
        @(negedge clk);
        check($sformatf("v%0d_wb_val", idx), {31'd0, bif.hs_bj4wb_val}, 32'd1);
        check($sformatf("v%0d_taken", idx), {31'd0, bif.o_taken}, {31'd0, v.exp_taken});
        check($sformatf("v%0d_setpc", idx), {31'd0, bif.o_setpc}, {31'd0, v.exp_setpc});
        check($sformatf("v%0d_newpc", idx), bif.o_newpc, v.exp_newpc);
        check($sformatf("v%0d_res", idx), bif.o_res, v.exp_res);
        check($sformatf("v%0d_misalign", idx), {31'd0, bif.o_misalign}, {31'd0, v.exp_mis});
        @(negedge clk);
        check($sformatf("v%0d_idle", idx), {30'd0, dbg_state}, {30'd0, S_IDLE});
        check($sformatf("v%0d_wb_drop", idx), {31'd0, bif.hs_bj4wb_val}, 32'd0);
    endtask

    initial begin
        int wb_seen;
        n_checks = 0;
        n_fails  = 0;
        // op,      opn1,        opn2,        imm,         pc,          pt, pred_pc,
        // cal, c1, c2, taken, setpc, newpc, res, mis
        vecs[0]  = '{8'h01, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 32'h0,
                     1'b1, 32'h100, 32'h20, 1'b1, 1'b1, 32'h120, 32'h0, 1'b0};
        vecs[1]  = '{8'h10, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h300, 1'b0, 32'h0,
                     1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h304, 32'h0, 1'b0};
        vecs[2]  = '{8'h04, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h300, 1'b1, 32'h340,
                     1'b1, 32'h300, 32'h40, 1'b1, 1'b0, 32'h340, 32'h0, 1'b0};
        vecs[3]  = '{8'h10, 32'hFFFFFFFF, 32'd1, 32'h40, 32'hFFFFFFFC, 1'b0, 32'h0,
                     1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[4]  = '{8'h80, 32'h1001, 32'd0, 32'h3, 32'h200, 1'b1, 32'h1004,
                     1'b1, 32'h1001, 32'h3, 1'b1, 1'b0, 32'h1004, 32'h204, 1'b0};
        vecs[5]  = '{8'h40, 32'd0, 32'd0, 32'h6, 32'h100, 1'b0, 32'h0,
                     1'b1, 32'h100, 32'h6, 1'b1, ~MIS_EN, 32'h106, 32'h104, MIS_EN};
        vecs[6]  = '{8'h02, 32'd7, 32'd7, 32'h10, 32'h400, 1'b1, 32'h500,
                     1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h404, 32'h0, 1'b0};
        vecs[7]  = '{8'h08, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h600, 1'b0, 32'h0,
                     1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h604, 32'h0, 1'b0};
        vecs[8]  = '{8'h20, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'h700, 1'b1, 32'h6F4,
                     1'b1, 32'h700, 32'hFFFFFFF0, 1'b1, 1'b1, 32'h6F0, 32'h0, 1'b0};
        vecs[9]  = '{8'h41, 32'd1, 32'd2, 32'h10, 32'h800, 1'b0, 32'h0,
                     1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h804, 32'h0, 1'b0};
        vecs[10] = '{8'h00, 32'd3, 32'd3, 32'h10, 32'h900, 1'b1, 32'h910,
                     1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h904, 32'h0, 1'b0};
        vecs[11] = '{8'h80, 32'h2000, 32'd0, 32'h5, 32'h10, 1'b1, 32'h2004,
                     1'b1, 32'h2000, 32'h5, 1'b1, 1'b0, 32'h2004, 32'h14, 1'b0};
        vecs[12] = '{8'h40, 32'd0, 32'd0, 32'h8, 32'hFFFFFFFC, 1'b1, 32'h4,
                     1'b1, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0};
        v_beq = vecs[0];

        rst_n            = 1'b0;
        bif.hs_ex4bj_val = 1'b0;
        bif.i_op         = '0;
        bif.i_opn1       = '0;
        bif.i_opn2       = '0;
        bif.i_imm        = '0;
        bif.i_pc         = '0;
        bif.i_pred_taken = 1'b0;
        bif.i_pred_pc    = '0;
        bif.i_flush      = 1'b0;
        bif.hs_cal4al_rdy = 1'b1;
        bif.hs_wb4bj_rdy = 1'b1;

        #12;
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("rst_ex_rdy", {31'd0, bif.hs_bj4ex_rdy}, 32'd1);
        check("rst_cal_val", {31'd0, bif.hs_al4cal_val}, 32'd0);
        check("rst_wb_val", {31'd0, bif.hs_bj4wb_val}, 32'd0);
        check("rst_newpc", bif.o_newpc, 32'd0);
        check("rst_setpc", {31'd0, bif.o_setpc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Calculator stalls three cycles, then writeback stalls two cycles.
        bif.hs_cal4al_rdy = 1'b0;
        bif.hs_wb4bj_rdy  = 1'b0;
        @(negedge clk);
        drive_op(v_beq);
        @(negedge clk);
        bif.hs_ex4bj_val = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_cal_val%0d", c), {31'd0, bif.hs_al4cal_val}, 32'd1);
            check($sformatf("bp_cal_opn1_%0d", c), bif.o_cal_opn1, 32'h100);
            check($sformatf("bp_cal_opn2_%0d", c), bif.o_cal_opn2, 32'h20);
            check($sformatf("bp_no_wb%0d", c), {31'd0, bif.hs_bj4wb_val}, 32'd0);
            if (c < 2) @(negedge clk);
        end
        bif.hs_cal4al_rdy = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("bp_wb_val%0d", c), {31'd0, bif.hs_bj4wb_val}, 32'd1);
            check($sformatf("bp_cal_drop%0d", c), {31'd0, bif.hs_al4cal_val}, 32'd0);
            check($sformatf("bp_newpc%0d", c), bif.o_newpc, 32'h120);
            check($sformatf("bp_setpc%0d", c), {31'd0, bif.o_setpc}, 32'd1);
            check($sformatf("bp_taken%0d", c), {31'd0, bif.o_taken}, 32'd1);
            if (c < 1) @(negedge clk);
        end
        bif.hs_wb4bj_rdy = 1'b1;
        @(negedge clk);
        check("bp_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("bp_ex_rdy", {31'd0, bif.hs_bj4ex_rdy}, 32'd1);

        // Flush while waiting for the calculator: op must vanish.
        bif.hs_cal4al_rdy = 1'b0;
        drive_op(v_beq);
        @(negedge clk);
        bif.hs_ex4bj_val = 1'b0;
        check("fl_calq", {30'd0, dbg_state}, {30'd0, S_CALQ});
        check("fl_cal_val", {31'd0, bif.hs_al4cal_val}, 32'd1);
        bif.i_flush = 1'b1;
        @(negedge clk);
        check("fl_cal_drop", {31'd0, bif.hs_al4cal_val}, 32'd0);
        check("fl_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("fl_ex_rdy_blocked", {31'd0, bif.hs_bj4ex_rdy}, 32'd0);
        bif.i_flush       = 1'b0;
        bif.hs_cal4al_rdy = 1'b1;
        wb_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bif.hs_bj4wb_val) wb_seen++;
        end
        check("fl_no_wb", wb_seen, 32'd0);
        check("fl_ex_rdy", {31'd0, bif.hs_bj4ex_rdy}, 32'd1);

        // Unit still works after the flush.
        run_vec(99, vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
